// File: rtl/bf_pkg.sv
// Shared brainfuck types and default widths for the tape controller, RAM and decoder.
// No logic; types and constants only.
// No flow control here.
package bf_pkg;

    localparam int BF_DATA_WIDTH = 8;
    localparam int BF_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PTR_INC = 3'd1,
        OP_PTR_DEC = 3'd2,
        OP_VAL_INC = 3'd3,
        OP_VAL_DEC = 3'd4,
        OP_OUT     = 3'd5,
        OP_IN      = 3'd6,
        OP_RSVD    = 3'd7
    } bf_op_t;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_OUT_WAIT = 2'd2,
        ST_IN_WAIT  = 2'd3
    } tape_state_t;

endpackage

// File: rtl/bf_tape_ctrl_if.sv
// Bundle of command, tape RAM, output and input signals around the tape controller.
// No latency of its own.
// master = controller side, slave = environment (decoder, RAM, byte I/O).
interface bf_tape_ctrl_if
    import bf_pkg::*;
#(
    parameter int DATA_WIDTH = BF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BF_ADDR_WIDTH
);
    logic                  cmd_valid;
    bf_op_t                cmd_op;
    logic                  cmd_ready;
    logic                  zero_flag;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (
        input  cmd_valid, cmd_op, mem_rdata, out_ready, in_valid, in_data,
        output cmd_ready, zero_flag, mem_addr, mem_wdata, out_valid, out_data, in_ready
    );

    modport slave (
        output cmd_valid, cmd_op, mem_rdata, out_ready, in_valid, in_data,
        input  cmd_ready, zero_flag, mem_addr, mem_wdata, out_valid, out_data, in_ready
    );
endinterface

// File: rtl/bf_tape_ctrl.sv
// Brainfuck tape controller: owns the data pointer, drives the always-writing tape RAM.
// Pointer/value ops 1 cycle; OUT/IN 1 cycle plus handshake; 2**ADDR_WIDTH-cycle clear after reset.
// cmd_ready only in IDLE; OUT holds out_data until out_ready, IN waits for in_valid.
module bf_tape_ctrl
    import bf_pkg::*;
#(
    parameter int DATA_WIDTH = BF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BF_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         nrst,
    bf_tape_ctrl_if.master bus
);

    tape_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  in_ready_q, in_ready_d;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cmd_ready;

    // Next state, pointer/counter updates and RAM traffic; the RAM writes every
    // cycle, so outside CLEAR the default write-back is the cell's own value.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        mem_addr    = ptr_q;
        mem_wdata   = bus.mem_rdata;
        cmd_ready   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_PTR_INC: ptr_d     = ptr_q + ADDR_WIDTH'(1);
                        OP_PTR_DEC: ptr_d     = ptr_q - ADDR_WIDTH'(1);
                        OP_VAL_INC: mem_wdata = bus.mem_rdata + DATA_WIDTH'(1);
                        OP_VAL_DEC: mem_wdata = bus.mem_rdata - DATA_WIDTH'(1);
                        OP_OUT: begin
                            out_data_d  = bus.mem_rdata;
                            out_valid_d = 1'b1;
                            state_d     = ST_OUT_WAIT;
                        end
                        OP_IN: begin
                            in_ready_d = 1'b1;
                            state_d    = ST_IN_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_IN_WAIT: begin
                if (bus.in_valid) begin
                    mem_wdata  = bus.in_data;
                    in_ready_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // State, pointer, clear counter and handshake registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cmd_ready = cmd_ready;
    assign bus.zero_flag = (bus.mem_rdata == '0);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.in_ready  = in_ready_q;

endmodule
